pll_reset_ctrl: RTL and testbench

- Sequencer for the board PLL (50 MHz refclk to 100 MHz / 40 MHz outputs).
- Drives the PLL reset and debounces its lock indication.
- Retries lock with a bounded retry budget and raises a sticky fault when the budget is exhausted.
- Emits a single sys_ready qualifier that downstream reset bridges use to release the 100/40 MHz domains; runs on the free-running 50 MHz reference clock.

---
 rtl/pll_ctrl_pkg.sv | 31 +++
 rtl/sync_2ff.sv | 29 ++
 rtl/pll_reset_ctrl.sv | 170 +++++++++++++++++
 tb/tb_pll_reset_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_ctrl_pkg.sv
// Shared definitions for the PLL reset sequencer and its CSR decode:
// state encoding, default timing constants and small helpers.
package pll_ctrl_pkg;

  // 3-bit state encoding exported on the debug/CSR bus.
  typedef enum logic [2:0] {
    ST_RST       = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_LOCKED    = 3'd3,
    ST_FAULT     = 3'd4
  } pll_state_e;

  // Default timing for a 50 MHz reference clock.
  localparam int unsigned DEF_RST_CYCLES    = 64;
  localparam int unsigned DEF_LOCK_TIMEOUT  = 50000;
  localparam int unsigned DEF_STABLE_CYCLES = 1024;
  localparam int unsigned DEF_MAX_RETRIES   = 3;
  localparam int unsigned DEF_RETRY_W       = 4;

  // Saturating 16-bit increment used for event counters.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // The PLL is held in reset while sequencing a fresh attempt or parked in FAULT.
  function automatic logic state_holds_pll_rst(input pll_state_e s);
    return (s == ST_RST) || (s == ST_FAULT);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for slow, level-type asynchronous signals.
// Each bit is synchronized independently; use only for bits that do not
// need to be coherent with one another.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Metastability stage followed by the stable output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_ctrl.sv
// PLL reset sequencer: holds the PLL in reset, waits for a debounced lock,
// retries a bounded number of times and parks in a sticky FAULT state when
// the retry budget runs out. sys_ready qualifies the downstream domains.
module pll_reset_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = DEF_RST_CYCLES,
  parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned MAX_RETRIES   = DEF_MAX_RETRIES,
  parameter int unsigned RETRY_W       = DEF_RETRY_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               pll_locked_async,
  input  logic               sw_reset_req,
  input  logic               fault_clear,
  output logic               pll_rst,
  output logic               sys_ready,
  output logic               fault,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic [15:0]        loss_cnt,
  output logic [2:0]         state
);

  localparam int unsigned RST_W = $clog2(RST_CYCLES) + 1;
  localparam int unsigned TMO_W = $clog2(LOCK_TIMEOUT) + 1;
  localparam int unsigned STB_W = $clog2(STABLE_CYCLES) + 1;

  localparam logic [RST_W-1:0]   RST_LAST  = RST_W'(RST_CYCLES - 1);
  localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(LOCK_TIMEOUT - 1);
  localparam logic [STB_W-1:0]   STB_LAST  = STB_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

  pll_state_e         state_q, state_d;
  logic [RST_W-1:0]   rst_cnt_q, rst_cnt_d;
  logic [TMO_W-1:0]   lock_tmr_q, lock_tmr_d;
  logic [STB_W-1:0]   stable_cnt_q, stable_cnt_d;
  logic [RETRY_W-1:0] retry_cnt_q, retry_cnt_d;
  logic [15:0]        loss_cnt_q, loss_cnt_d;
  logic               pll_rst_q, sys_ready_q, fault_q;
  logic               locked_s;

  // Only the synchronized lock is ever looked at inside this module.
  sync_2ff #(
    .WIDTH (1)
  ) u_lock_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .d_i   (pll_locked_async),
    .q_o   (locked_s)
  );

  // Next-state, counter and event logic; every register holds by default.
  always_comb begin
    state_d      = state_q;
    rst_cnt_d    = rst_cnt_q;
    lock_tmr_d   = lock_tmr_q;
    stable_cnt_d = stable_cnt_q;
    retry_cnt_d  = retry_cnt_q;
    loss_cnt_d   = loss_cnt_q;

    if (sw_reset_req && (state_q != ST_FAULT)) begin
      // Software re-sequence beats every other transition, including a
      // simultaneous lock loss, so loss_cnt is deliberately left alone.
      state_d   = ST_RST;
      rst_cnt_d = '0;
    end else begin
      unique case (state_q)
        ST_RST: begin
          if (rst_cnt_q >= RST_LAST) begin
            state_d    = ST_WAIT_LOCK;
            lock_tmr_d = '0;
          end else begin
            rst_cnt_d = rst_cnt_q + RST_W'(1);
          end
        end

        ST_WAIT_LOCK: begin
          if (locked_s) begin
            state_d      = ST_STABLE;
            stable_cnt_d = '0;
            // Time spent waiting still counts; the timer saturates at its
            // last value so a late return from STABLE times out at once.
            if (lock_tmr_q < TMO_LAST) begin
              lock_tmr_d = lock_tmr_q + TMO_W'(1);
            end
          end else if (lock_tmr_q >= TMO_LAST) begin
            if (retry_cnt_q >= RETRY_MAX) begin
              state_d = ST_FAULT;
            end else begin
              state_d     = ST_RST;
              rst_cnt_d   = '0;
              retry_cnt_d = retry_cnt_q + RETRY_W'(1);
            end
          end else begin
            lock_tmr_d = lock_tmr_q + TMO_W'(1);
          end
        end

        ST_STABLE: begin
          // Lock timer is frozen here and not cleared on the way back, so a
          // chattering lock accumulates WAIT_LOCK time until it times out.
          if (!locked_s) begin
            state_d = ST_WAIT_LOCK;
          end else if (stable_cnt_q >= STB_LAST) begin
            state_d     = ST_LOCKED;
            retry_cnt_d = '0;
          end else begin
            stable_cnt_d = stable_cnt_q + STB_W'(1);
          end
        end

        ST_LOCKED: begin
          if (!locked_s) begin
            state_d    = ST_RST;
            rst_cnt_d  = '0;
            loss_cnt_d = sat_inc16(loss_cnt_q);
          end
        end

        ST_FAULT: begin
          if (fault_clear) begin
            state_d     = ST_RST;
            rst_cnt_d   = '0;
            retry_cnt_d = '0;
          end
        end

        default: begin
          state_d   = ST_RST;
          rst_cnt_d = '0;
        end
      endcase
    end
  end

  // State, counters and registered outputs decoded from the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_RST;
      rst_cnt_q    <= '0;
      lock_tmr_q   <= '0;
      stable_cnt_q <= '0;
      retry_cnt_q  <= '0;
      loss_cnt_q   <= '0;
      pll_rst_q    <= 1'b1;
      sys_ready_q  <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      lock_tmr_q   <= lock_tmr_d;
      stable_cnt_q <= stable_cnt_d;
      retry_cnt_q  <= retry_cnt_d;
      loss_cnt_q   <= loss_cnt_d;
      pll_rst_q    <= state_holds_pll_rst(state_d);
      sys_ready_q  <= (state_d == ST_LOCKED);
      fault_q      <= (state_d == ST_FAULT);
    end
  end

  assign pll_rst   = pll_rst_q;
  assign sys_ready = sys_ready_q;
  assign fault     = fault_q;
  assign retry_cnt = retry_cnt_q;
  assign loss_cnt  = loss_cnt_q;
  assign state     = state_q;

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Directed bench for pll_reset_ctrl: expected values are queued when the
// stimulus is applied and popped when the DUT outputs are sampled.
module tb_pll_reset_ctrl;

  localparam int unsigned RETRY_W = 4;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               pll_locked_async;
  logic               sw_reset_req;
  logic               fault_clear;
  logic               pll_rst;
  logic               sys_ready;
  logic               fault;
  logic [RETRY_W-1:0] retry_cnt;
  logic [15:0]        loss_cnt;
  logic [2:0]         state;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  pll_reset_ctrl #(
    .RST_CYCLES    (8),
    .LOCK_TIMEOUT  (100),
    .STABLE_CYCLES (16),
    .MAX_RETRIES   (2),
    .RETRY_W       (RETRY_W)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .pll_locked_async (pll_locked_async),
    .sw_reset_req     (sw_reset_req),
    .fault_clear      (fault_clear),
    .pll_rst          (pll_rst),
    .sys_ready        (sys_ready),
    .fault            (fault),
    .retry_cnt        (retry_cnt),
    .loss_cnt         (loss_cnt),
    .state            (state)
  );

  always #10 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_err++;
      $error("FAIL scoreboard_underflow: observed %0d expected <none>", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.exp) else begin
        n_err++;
        $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.exp);
      end
    end
  endtask

  // Bounded wait for a state; a timeout shows up as a state comparison failure.
  task automatic wait_state(input logic [2:0] st, input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      if (state == st) break;
      tick(1);
    end
    push(tag, 32'(st));
    chk(32'(state));
  endtask

  task automatic push_reset_vals(input string tag);
    push({tag, "_state"}, 32'd0);
    push({tag, "_pll_rst"}, 32'd1);
    push({tag, "_sys_ready"}, 32'd0);
    push({tag, "_fault"}, 32'd0);
    push({tag, "_retry"}, 32'd0);
    push({tag, "_loss"}, 32'd0);
  endtask

  task automatic chk_reset_vals();
    chk(32'(state));
    chk(32'(pll_rst));
    chk(32'(sys_ready));
    chk(32'(fault));
    chk(32'(retry_cnt));
    chk(32'(loss_cnt));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen_ready;
    bit seen_stable;
    int elapsed;

    reset_n          = 1'b0;
    pll_locked_async = 1'b0;
    sw_reset_req     = 1'b0;
    fault_clear      = 1'b0;

    // Reset values while reset_n is held low.
    push_reset_vals("por");
    tick(3);
    chk_reset_vals();

    // Clean lock: pll_rst held for exactly 8 cycles after release.
    reset_n = 1'b1;
    push("clean_rst_hold", 32'd1);
    tick(7);
    chk(32'(pll_rst));
    push("clean_rst_rel", 32'd0);
    push("clean_wait_state", 32'd1);
    tick(1);
    chk(32'(pll_rst));
    chk(32'(state));

    // Lock rises 20 cycles after release: 2 sync edges, 1 to enter STABLE,
    // 16 STABLE cycles, then LOCKED.
    tick(12);
    pll_locked_async = 1'b1;
    push("clean_stable", 32'd2);
    push("clean_not_ready", 32'd0);
    tick(18);
    chk(32'(state));
    chk(32'(sys_ready));
    push("clean_locked", 32'd3);
    push("clean_ready", 32'd1);
    push("clean_retry", 32'd0);
    push("clean_fault", 32'd0);
    tick(1);
    chk(32'(state));
    chk(32'(sys_ready));
    chk(32'(retry_cnt));
    chk(32'(fault));

    // Lock loss in LOCKED: sys_ready drops on the 3rd edge after the drop.
    tick(5);
    pll_locked_async = 1'b0;
    push("loss_ready_edge2", 32'd1);
    tick(2);
    chk(32'(sys_ready));
    push("loss_ready_edge3", 32'd0);
    push("loss_state", 32'd0);
    push("loss_cnt_1", 32'd1);
    push("loss_pll_rst", 32'd1);
    tick(1);
    chk(32'(sys_ready));
    chk(32'(state));
    chk(32'(loss_cnt));
    chk(32'(pll_rst));
    push("loss_rst_hold", 32'd1);
    tick(7);
    chk(32'(pll_rst));
    push("loss_rst_rel", 32'd0);
    tick(1);
    chk(32'(pll_rst));

    // Relock after loss.
    pll_locked_async = 1'b1;
    push("relock_stable", 32'd2);
    tick(18);
    chk(32'(state));
    push("relock_locked", 32'd3);
    push("relock_ready", 32'd1);
    tick(1);
    chk(32'(state));
    chk(32'(sys_ready));

    // Priority: sw_reset_req in the cycle locked_s falls; loss_cnt stays 1.
    tick(3);
    pll_locked_async = 1'b0;
    tick(2);
    sw_reset_req = 1'b1;
    push("prio_state", 32'd0);
    push("prio_loss", 32'd1);
    push("prio_ready", 32'd0);
    tick(1);
    sw_reset_req = 1'b0;
    chk(32'(state));
    chk(32'(loss_cnt));
    chk(32'(sys_ready));

    // Never lock: each attempt is 8 RST + 100 WAIT_LOCK cycles.
    push("nolock1_wait", 32'd1);
    push("nolock1_retry0", 32'd0);
    tick(107);
    chk(32'(state));
    chk(32'(retry_cnt));
    push("nolock1_rst", 32'd0);
    push("nolock1_retry1", 32'd1);
    tick(1);
    chk(32'(state));
    chk(32'(retry_cnt));
    push("nolock2_wait", 32'd1);
    tick(107);
    chk(32'(state));
    push("nolock2_rst", 32'd0);
    push("nolock2_retry2", 32'd2);
    tick(1);
    chk(32'(state));
    chk(32'(retry_cnt));
    push("nolock3_wait", 32'd1);
    tick(107);
    chk(32'(state));
    push("fault_state", 32'd4);
    push("fault_flag", 32'd1);
    push("fault_pll_rst", 32'd1);
    push("fault_ready", 32'd0);
    push("fault_retry", 32'd2);
    tick(1);
    chk(32'(state));
    chk(32'(fault));
    chk(32'(pll_rst));
    chk(32'(sys_ready));
    chk(32'(retry_cnt));

    // sw_reset_req is ignored in FAULT.
    tick(3);
    sw_reset_req = 1'b1;
    push("fault_sw_ignored", 32'd4);
    push("fault_sw_flag", 32'd1);
    tick(1);
    sw_reset_req = 1'b0;
    tick(2);
    chk(32'(state));
    chk(32'(fault));

    // fault_clear leaves FAULT.
    fault_clear = 1'b1;
    push("fclr_state", 32'd0);
    push("fclr_retry", 32'd0);
    push("fclr_fault", 32'd0);
    tick(1);
    fault_clear = 1'b0;
    chk(32'(state));
    chk(32'(retry_cnt));
    chk(32'(fault));

    // Chatter: toggling every 10 cycles never completes STABLE, and the
    // frozen-not-cleared lock timer still times out the attempt.
    seen_ready  = 1'b0;
    seen_stable = 1'b0;
    elapsed     = 0;
    for (int i = 0; i < 400; i++) begin
      if ((i % 10) == 9) pll_locked_async = ~pll_locked_async;
      tick(1);
      if (sys_ready) seen_ready = 1'b1;
      if (state == 3'd2) seen_stable = 1'b1;
      if (retry_cnt != '0) begin
        elapsed = i + 1;
        break;
      end
    end
    pll_locked_async = 1'b0;
    push("chat_retry", 32'd1);
    push("chat_state", 32'd0);
    push("chat_no_ready", 32'd0);
    push("chat_saw_stable", 32'd1);
    push("chat_elapsed_range", 32'd1);
    chk(32'(retry_cnt));
    chk(32'(state));
    chk(32'(seen_ready));
    chk(32'(seen_stable));
    chk(32'((elapsed > 108) && (elapsed < 300)));

    // Async reset at stable count 10.
    pll_locked_async = 1'b1;
    wait_state(3'd2, 40, "mid_reach_stable");
    tick(10);
    push("mid_still_stable", 32'd2);
    chk(32'(state));
    reset_n = 1'b0;
    #1;
    push_reset_vals("mid_rst");
    chk_reset_vals();

    // Full restart after release with lock already high.
    tick(1);
    reset_n = 1'b1;
    push("restart_rst_hold", 32'd1);
    tick(7);
    chk(32'(pll_rst));
    push("restart_wait", 32'd1);
    tick(1);
    chk(32'(state));
    push("restart_stable", 32'd2);
    tick(1);
    chk(32'(state));
    push("restart_stable_end", 32'd2);
    tick(15);
    chk(32'(state));
    push("restart_locked", 32'd3);
    push("restart_ready", 32'd1);
    tick(1);
    chk(32'(state));
    chk(32'(sys_ready));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
